// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 access codes and FSM state encoding shared by the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_MERGE,
        S_RESP
    } state_t;

    function automatic logic f3_legal(input logic [2:0] f);
        return (f == F3_B) || (f == F3_H) || (f == F3_W) || (f == F3_BU) || (f == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load lane extract/extend and store lane merge for one memory word.
import lsu_pkg::*;

module lsu_align (
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    input  logic [15:0] store_lo,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Halfword lane comes from off[1] only, so odd halfword offsets fold onto their lane.
    always_comb begin
        shifted = word >> {off, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = off[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
            F3_H:    load_data = {{16{half_v[15]}}, half_v};
            F3_W:    load_data = word;
            F3_BU:   load_data = {24'h0, byte_v};
            F3_HU:   load_data = {16'h0, half_v};
            default: load_data = 32'h0;
        endcase
    end

    always_comb begin
        merge_data = word;
        case (funct3[1:0])
            2'b00: merge_data[{off, 3'b000} +: 8] = store_lo[7:0];
            2'b01: begin
                if (off[1]) merge_data[31:16] = store_lo;
                else        merge_data[15:0]  = store_lo;
            end
            default: merge_data = word;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit with RMW sub-word stores; LSU_MISALIGN_TRAP_EN enables misalignment trapping.
import lsu_pkg::*;

module lsu_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    output logic              o_ready,
    input  logic              i_we,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_misaligned,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] merge_q;
    logic [DATA_W-1:0] rdata_q;
    logic [31:0]       load_data;
    logic [31:0]       merge_data;
    logic              trap;

    lsu_align u_align (
        .funct3     (funct3_q),
        .off        (addr_q[1:0]),
        .word       (i_mem_rdata),
        .store_lo   (wdata_q[15:0]),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q;

    assign trap = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                  ((i_funct3 == F3_W) && (i_addr[1:0] != 2'b00));
    assign o_misaligned = mis_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                          mis_q <= 1'b0;
        else if (state == S_IDLE && i_req)  mis_q <= trap;
    end
`else
    assign trap         = 1'b0;
    assign o_misaligned = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            wdata_q  <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_req) begin
                        addr_q   <= i_addr;
                        we_q     <= i_we;
                        funct3_q <= i_funct3;
                        wdata_q  <= i_wdata;
                        state    <= trap ? S_RESP : S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!f3_legal(funct3_q)) begin
                        rdata_q <= '0;
                        state   <= S_RESP;
                    end else if (!we_q) begin
                        rdata_q <= load_data;
                        state   <= S_RESP;
                    end else if (funct3_q == F3_W) begin
                        state <= S_RESP;
                    end else begin
                        merge_q <= merge_data;
                        state   <= S_MERGE;
                    end
                end
                S_MERGE: state <= S_RESP;
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Write enable decodes from state alone so an async reset drops it immediately.
    assign o_mem_we    = ((state == S_ACCESS) && we_q && (funct3_q == F3_W)) || (state == S_MERGE);
    assign o_mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign o_mem_wdata = (state == S_MERGE) ? merge_q : wdata_q;
    assign o_ready     = (state == S_IDLE);
    assign o_valid     = (state == S_RESP);
    assign o_rdata     = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - randomized self-checking bench for lsu_ctrl against a word-array memory model.
module tb_lsu_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req = 1'b0;
    logic        o_ready;
    logic        i_we = 1'b0;
    logic [2:0]  i_funct3 = 3'b000;
    logic [31:0] i_addr = 32'h0;
    logic [31:0] i_wdata = 32'h0;
    logic        o_valid;
    logic [31:0] o_rdata;
    logic        o_misaligned;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [0:63];
    logic [31:0] ref_mem [0:63];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = 6'd0;
    logic [31:0] pl_data = 32'h0;
    int          we_cnt = 0;
    logic [31:0] last_waddr = 32'h0;
    logic [31:0] exp_rdata = 32'h0;

    always #5 i_clk = ~i_clk;

    lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req        (i_req),
        .o_ready      (o_ready),
        .i_we         (i_we),
        .i_funct3     (i_funct3),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .o_valid      (o_valid),
        .o_rdata      (o_rdata),
        .o_misaligned (o_misaligned),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_rdata  (i_mem_rdata)
    );

    assign i_mem_rdata = mem[o_mem_addr[7:2]];

    always @(posedge i_clk) begin
        if (pl_en)         mem[pl_idx] <= pl_data;
        else if (o_mem_we) mem[o_mem_addr[7:2]] <= o_mem_wdata;
    end

    always @(negedge i_clk) begin
        if (o_mem_we) begin
            we_cnt     = we_cnt + 1;
            last_waddr = o_mem_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] d);
        @(negedge i_clk);
        pl_en   = 1'b1;
        pl_idx  = idx[5:0];
        pl_data = d;
        @(posedge i_clk);
        #1 pl_en = 1'b0;
        ref_mem[idx] = d;
    endtask

    task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int          idx, off, sh, lat, exp_we, n, w0;
        logic        mis, legal;
        logic [31:0] word, b, h, mask;
        idx   = int'(a[7:2]);
        off   = int'(a[1:0]);
        word  = ref_mem[idx];
        mis   = TRAP && ((((f3 == 3'd1) || (f3 == 3'd5)) && a[0]) || ((f3 == 3'd2) && (off != 0)));
        legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        b = (word >> (8 * off)) & 32'hFF;
        h = (word >> (16 * (off / 2))) & 32'hFFFF;
        exp_we = 0;
        if (mis) begin
            lat = 1;
        end else if (!legal) begin
            lat = 2;
            exp_rdata = 32'h0;
        end else if (!we) begin
            lat = 2;
            case (f3)
                3'd0:    exp_rdata = (b >= 128) ? (b | 32'hFFFF_FF00) : b;
                3'd1:    exp_rdata = (h >= 32768) ? (h | 32'hFFFF_0000) : h;
                3'd4:    exp_rdata = b;
                3'd5:    exp_rdata = h;
                default: exp_rdata = word;
            endcase
        end else if (f3 == 3'd2) begin
            lat = 2;
            exp_we = 1;
            ref_mem[idx] = wd;
        end else begin
            lat = 3;
            exp_we = 1;
            sh   = (f3[0] == 1'b0) ? 8 * off : 16 * (off / 2);
            mask = ((f3[0] == 1'b0) ? 32'hFF : 32'hFFFF) << sh;
            ref_mem[idx] = (word & ~mask) | ((wd << sh) & mask);
        end

        @(negedge i_clk);
        check("ready_before_req", {31'h0, o_ready}, 32'h1);
        i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = a; i_wdata = wd;
        w0 = we_cnt;
        @(posedge i_clk);
        #1 i_req = 1'b0;
        n = 1;
        while (!o_valid && n < 8) begin
            @(posedge i_clk);
            #1 n = n + 1;
        end
        check("latency", n, lat);
        check("rdata", o_rdata, exp_rdata);
        check("misaligned", {31'h0, o_misaligned}, {31'h0, mis});
        check("mem_we_pulses", we_cnt - w0, exp_we);
        check("mem_word", mem[idx], ref_mem[idx]);
        if (exp_we == 1) check("mem_waddr", last_waddr, {24'h0, a[7:2], 2'b00});
        @(posedge i_clk);
        #1;
        check("valid_one_cycle", {31'h0, o_valid}, 32'h0);
    endtask

    initial begin
        int w0;
        logic [2:0] f3;
        logic       we;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        check("rst_ready", {31'h0, o_ready}, 32'h1);
        check("rst_valid", {31'h0, o_valid}, 32'h0);
        check("rst_rdata", o_rdata, 32'h0);
        check("rst_misaligned", {31'h0, o_misaligned}, 32'h0);
        check("rst_mem_we", {31'h0, o_mem_we}, 32'h0);
        check("rst_mem_addr", o_mem_addr, 32'h0);
        check("rst_mem_wdata", o_mem_wdata, 32'h0);

        for (int i = 0; i < 64; i++) preload(i, $urandom);
        preload(4, 32'h8081_F2F3);

        do_op(1'b0, 3'd0, 32'h11, 32'h0);
        check("lb_const", o_rdata, 32'hFFFF_FFF2);
        do_op(1'b0, 3'd4, 32'h11, 32'h0);
        check("lbu_const", o_rdata, 32'h0000_00F2);
        do_op(1'b0, 3'd1, 32'h12, 32'h0);
        check("lh_const", o_rdata, 32'hFFFF_8081);
        do_op(1'b0, 3'd5, 32'h12, 32'h0);
        check("lhu_const", o_rdata, 32'h0000_8081);
        do_op(1'b0, 3'd2, 32'h10, 32'h0);
        check("lw_const", o_rdata, 32'h8081_F2F3);

        preload(4, 32'h1122_3344);
        do_op(1'b1, 3'd0, 32'h13, 32'hAA);
        check("sb_const", mem[4], 32'hAA22_3344);
        do_op(1'b1, 3'd2, 32'h20, 32'hDEAD_BEEF);
        do_op(1'b0, 3'd2, 32'h20, 32'h0);
        check("lw_after_sw", o_rdata, 32'hDEAD_BEEF);
        do_op(1'b0, 3'd2, 32'h22, 32'h0);
        do_op(1'b0, 3'd3, 32'h24, 32'h0);
        do_op(1'b0, 3'd1, 32'h31, 32'h0);

        for (int i = 0; i < 40; i++) begin
            we = ($urandom_range(0, 2) == 0);
            if (we) f3 = 3'($urandom_range(0, 2));
            else begin
                case ($urandom_range(0, 6))
                    0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4;
                    4: f3 = 3'd5; 5: f3 = 3'd3; default: f3 = 3'd6;
                endcase
            end
            do_op(we, f3, 32'($urandom_range(0, 255)), $urandom);
        end

        // Reset landing in the MERGE cycle of a byte store must abort the write.
        preload(5, 32'h1122_3344);
        @(negedge i_clk);
        i_req = 1'b1; i_we = 1'b1; i_funct3 = 3'd0; i_addr = 32'h17; i_wdata = 32'hAA;
        @(posedge i_clk);
        #1 i_req = 1'b0;
        @(posedge i_clk);
        #1 check("merge_we_high", {31'h0, o_mem_we}, 32'h1);
        w0 = we_cnt;
        #1 i_rst = 1'b1;
        #1;
        check("rst_mid_we", {31'h0, o_mem_we}, 32'h0);
        check("rst_mid_ready", {31'h0, o_ready}, 32'h1);
        check("rst_mid_valid", {31'h0, o_valid}, 32'h0);
        @(negedge i_clk);
        i_rst = 1'b0;
        exp_rdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(posedge i_clk);
            #1 check("rst_mid_no_valid", {31'h0, o_valid}, 32'h0);
        end
        check("rst_mid_mem", mem[5], 32'h1122_3344);
        check("rst_mid_we_cnt", we_cnt - w0, 0);
        check("rst_mid_rdata", o_rdata, exp_rdata);
        do_op(1'b0, 3'd2, 32'h14, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit placed between the core's execute stage and the word-addressed data memory. Accepts one load or store request at a time from the core, drives the memory's full-word read/write port, sign/zero-extends load data, and implements byte/halfword stores as read-modify-write because the memory only supports full-word writes. Returns a one-cycle completion pulse with load data or a misalignment flag.

## Interface
Parameters:
- ADDR_W, 32, byte-address width on core and memory sides
- DATA_W, 32, data width; only 32 is supported

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  reset; asynchronous assert, active-high
- i_req  in  1  core request valid; sampled only when o_ready=1
- o_ready  out  1  unit idle and able to accept a request
- i_we  in  1  1 = store, 0 = load
- i_funct3  in  3  RISC-V access type: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_addr  in  ADDR_W  byte address
- i_wdata  in  DATA_W  store data, right-justified
- o_valid  out  1  one-cycle completion pulse
- o_rdata  out  DATA_W  extended load data; valid with o_valid
- o_misaligned  out  1  access misaligned; valid with o_valid
- o_mem_we  out  1  memory write enable
- o_mem_addr  out  ADDR_W  memory byte address, bits [1:0] always 00
- o_mem_wdata  out  DATA_W  memory write word
- i_mem_rdata  in  DATA_W  memory read word, combinational from o_mem_addr

## Operation
- FSM states: IDLE, ACCESS, MERGE, RESP.
- IDLE: o_ready=1. On i_req, register addr, we, funct3, wdata; go to ACCESS (or RESP on trapped misalignment).
- ACCESS: o_mem_addr = {addr[31:2],00}.
  - Load: extract byte addr[1:0] / halfword addr[1] / word from i_mem_rdata; sign-extend for B/H, zero-extend for BU/HU; register into o_rdata; go RESP.
  - SW: o_mem_we=1, o_mem_wdata=wdata; go RESP.
  - SB/SH: o_mem_we=0; register i_mem_rdata with the target byte/halfword lane replaced by wdata[7:0]/[15:0]; go MERGE.
  - Illegal funct3 (011, 110, 111): no write, o_rdata=0; go RESP.
- MERGE: o_mem_we=1, o_mem_wdata = merged word; go RESP.
- RESP: o_valid=1 for exactly one cycle; go IDLE.
- o_mem_we is decoded from state only: 1 in ACCESS for SW, 1 in MERGE; 0 otherwise.
- o_rdata holds its value until the next load completes. Stores leave o_rdata unchanged.

## Timing
- Reset values:
  - state IDLE, o_ready=1, o_valid=0, o_rdata=0, o_misaligned=0, o_mem_we=0
  - registered addr/wdata=0, so o_mem_addr=0 and o_mem_wdata=0
- Latency from the accepting edge to the o_valid cycle:
  - load: 2 cycles
  - SW: 2 cycles
  - SB/SH: 3 cycles
  - trapped misaligned access: 1 cycle
- The next request can be accepted on the cycle after RESP. No back-to-back acceptance.
- Reset mid-operation: FSM returns to IDLE immediately and o_mem_we drops combinationally. An RMW interrupted before the MERGE edge leaves memory unmodified.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - H/HU with addr[0]=1, or W with addr[1:0]!=00, skips memory and goes IDLE->RESP.
  - o_misaligned=1 with o_valid; o_rdata unchanged; no write.
- LSU_MISALIGN_TRAP_EN undefined:
  - Offending low address bits are ignored: H uses lane addr[1], W uses the whole word.
  - o_misaligned is tied to 0.

## Structure
- lsu_pkg holds the funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the state enum.
- One combinational sub-module, lsu_align, performs the load lane extract/extend and the store lane merge. It is shared by ACCESS-state logic.

## Test plan
- Reset, then preload memory word 0x10 = 0x8081_F2F3. LB at 0x11 -> o_rdata=0xFFFF_FFF2, o_valid 2 cycles after accept. LBU at 0x11 -> 0x0000_00F2.
- LH at 0x12 -> 0xFFFF_8081. LHU at 0x12 -> 0x0000_8081. LW at 0x10 -> 0x8081_F2F3.
- SB 0xAA at 0x13 onto 0x1122_3344 -> one o_mem_we pulse in MERGE writing 0xAA22_3344. o_valid at 3 cycles.
- SW 0xDEAD_BEEF at 0x20 -> o_mem_we in ACCESS with o_mem_addr=0x20. Then LW 0x20 returns 0xDEAD_BEEF.
- LW at 0x22:
  - with macro: o_valid next cycle, o_misaligned=1, no o_mem_we.
  - without macro: reads word 0x20, o_misaligned=0.
- Assert i_rst during MERGE of an SB -> o_mem_we falls immediately, o_ready=1, memory word unchanged, no o_valid.
